// File: rtl/sub2_pkg.sv
// Shared types and frame layout for the sub2 byte-stream bridge.
package sub2_pkg;
  typedef logic [7:0] byte_t;
  typedef logic [0:2][7:0] arr3_t;

  localparam int FRAME_BYTES = 7;
  localparam int HDR_E       = 0;
  localparam int HDR_F_LSB   = 1;

  typedef enum logic [1:0] {RX, WAIT, TX} state_t;
endpackage

// File: rtl/sub2_link.sv
// Deserializes a 7-byte request onto sub2's inputs, waits RSP_LAT cycles,
// then serializes sub2's outputs back as a 7-byte response.
module sub2_link
  import sub2_pkg::*;
#(
  parameter int RSP_LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  byte_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output byte_t out_data,
  output logic  busy,
  output logic  sig_e,
  output logic [1:0] sig_f,
  output arr3_t sig_g,
  output byte_t sig_h [0:2],
  input  logic  sig_i,
  input  logic [1:0] sig_j,
  input  arr3_t sig_k,
  input  byte_t sig_l [0:2]
);
  localparam int LAST = FRAME_BYTES - 1;

  // Handshake rule on both channels: a byte moves on a rising edge where
  // valid && ready are both high; the sender holds data stable until then.

  state_t     state;
  logic [2:0] byte_cnt;
  logic [3:0] wait_cnt;
  byte_t      stage [0:LAST-1];
  byte_t      rsp   [0:LAST];

  assign in_ready = rst_n && (state == RX);
  assign busy     = (state != RX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RX;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sig_e     <= 1'b0;
      sig_f     <= '0;
      sig_g     <= '0;
      for (int i = 0; i < 3; i++) sig_h[i] <= '0;
      for (int i = 0; i < LAST; i++) stage[i] <= '0;
      for (int i = 0; i <= LAST; i++) rsp[i] <= '0;
    end else begin
      case (state)
        RX: begin
          if (in_valid) begin
            if (byte_cnt == 3'(LAST)) begin
              // Whole bundle is loaded in one edge so sub2 never sees a mixed frame.
              sig_e    <= stage[0][HDR_E];
              sig_f    <= stage[0][HDR_F_LSB +: 2];
              sig_g    <= {stage[1], stage[2], stage[3]};
              sig_h[0] <= stage[4];
              sig_h[1] <= stage[5];
              sig_h[2] <= in_data;
              byte_cnt <= '0;
              wait_cnt <= 4'd1;
              state    <= WAIT;
            end else begin
              stage[byte_cnt] <= in_data;
              byte_cnt        <= byte_cnt + 3'd1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'(RSP_LAT)) begin
            rsp[0]    <= {5'b0, sig_j, sig_i};
            rsp[1]    <= sig_k[0];
            rsp[2]    <= sig_k[1];
            rsp[3]    <= sig_k[2];
            rsp[4]    <= sig_l[0];
            rsp[5]    <= sig_l[1];
            rsp[6]    <= sig_l[2];
            out_data  <= {5'b0, sig_j, sig_i};
            out_valid <= 1'b1;
            wait_cnt  <= '0;
            state     <= TX;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        TX: begin
          if (out_ready) begin
            if (byte_cnt == 3'(LAST)) begin
              state     <= RX;
              byte_cnt  <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              out_data <= rsp[byte_cnt + 3'd1];
            end
          end
        end
        default: state <= RX;
      endcase
    end
  end
endmodule

// File: tb/tb_sub2_link.sv
// Drives two sub2_link instances (loopback at RSP_LAT=1, 3-cycle delayed stub at
// RSP_LAT=4) with the same request frames and checks both against a frame model.
module tb_sub2_link;
  import sub2_pkg::*;

  localparam int LAT_LB  = 1;
  localparam int LAT_DLY = 4;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  byte_t in_data = '0;
  logic  out_ready = 1'b1;

  logic       rdy [2];
  logic       ov  [2];
  byte_t      od  [2];
  logic       bsy [2];
  logic       e_s [2];
  logic [1:0] f_s [2];
  arr3_t      g_s [2];
  byte_t      h0 [0:2];
  byte_t      h1 [0:2];

  logic        i1;
  logic [1:0]  j1;
  arr3_t       k1;
  byte_t       l1 [0:2];
  logic [50:0] dl1, dl2, dl3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit bp_mode = 1'b0;

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub2_link #(.RSP_LAT(LAT_LB)) u_lb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .busy(bsy[0]),
    .sig_e(e_s[0]), .sig_f(f_s[0]), .sig_g(g_s[0]), .sig_h(h0),
    .sig_i(e_s[0]), .sig_j(f_s[0]), .sig_k(g_s[0]), .sig_l(h0)
  );

  sub2_link #(.RSP_LAT(LAT_DLY)) u_dly (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .busy(bsy[1]),
    .sig_e(e_s[1]), .sig_f(f_s[1]), .sig_g(g_s[1]), .sig_h(h1),
    .sig_i(i1), .sig_j(j1), .sig_k(k1), .sig_l(l1)
  );

  // Stub standing in for sub2: three registered stages of delay.
  always @(posedge clk) begin
    dl1 <= {e_s[1], f_s[1], g_s[1], h1[0], h1[1], h1[2]};
    dl2 <= dl1;
    dl3 <= dl2;
  end
  assign i1    = dl3[50];
  assign j1    = dl3[49:48];
  assign k1    = dl3[47:24];
  assign l1[0] = dl3[23:16];
  assign l1[1] = dl3[15:8];
  assign l1[2] = dl3[7:0];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  byte_t       fb [2][7];
  int          fcnt [2];
  bit          busy_m [2];
  int          start_cyc [2];
  int          tx_n [2];
  int          got_n [2];
  byte_t       got [2][7];
  int          wait_n [2];
  logic        sm_e [2];
  logic [1:0]  sm_f [2];
  logic [23:0] sm_g [2];
  byte_t       sm_h [2][3];
  bit          hold_v [2];
  byte_t       hold_d [2];
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];

  logic        m_acc;
  byte_t       m_h [3];
  byte_t       exp_b;
  int          q_size;

  initial begin
    for (int d = 0; d < 2; d++) begin
      fcnt[d] = 0; busy_m[d] = 0; start_cyc[d] = 0; tx_n[d] = 0; got_n[d] = 0;
      wait_n[d] = 0; sm_e[d] = 0; sm_f[d] = 0; sm_g[d] = 0; hold_v[d] = 0; hold_d[d] = 0;
      for (int i = 0; i < 3; i++) sm_h[d][i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_acc = rst_n && in_valid && !busy_m[d];
      for (int i = 0; i < 3; i++) m_h[i] = (d == 0) ? h0[i] : h1[i];
      if (armed) begin
        check("in_ready", rdy[d], rst_n && !busy_m[d]);
        check("busy", bsy[d], busy_m[d]);
        check("out_valid", ov[d], busy_m[d] && (cyc >= start_cyc[d]));
        if (!ov[d]) check("out_data_idle", od[d], 0);
        check("sig_e", e_s[d], sm_e[d]);
        check("sig_f", f_s[d], sm_f[d]);
        check("sig_g", g_s[d], sm_g[d]);
        for (int i = 0; i < 3; i++) check("sig_h", m_h[i], sm_h[d][i]);
        if (hold_v[d] && ov[d]) check("out_data_hold", od[d], hold_d[d]);
        if (rst_n && bsy[d] && !ov[d]) wait_n[d]++;
        if (rst_n && ov[d] && out_ready) begin
          q_size = (d == 0) ? exp_q0.size() : exp_q1.size();
          check("resp_expected", q_size > 0, 1);
          if (q_size > 0) begin
            exp_b = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("resp_byte", od[d], exp_b);
          end
          if (tx_n[d] < 7) got[d][tx_n[d]] = od[d];
          tx_n[d]++;
          got_n[d] = tx_n[d];
          if (tx_n[d] == 7) busy_m[d] = 0;
        end
      end
      hold_v[d] = rst_n && ov[d] && !out_ready;
      hold_d[d] = od[d];
      if (!rst_n) begin
        busy_m[d] = 0; fcnt[d] = 0; tx_n[d] = 0;
        sm_e[d] = 0; sm_f[d] = 0; sm_g[d] = 0;
        for (int i = 0; i < 3; i++) sm_h[d][i] = 0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (m_acc) begin
        fb[d][fcnt[d]] = in_data;
        fcnt[d]++;
        if (fcnt[d] == 7) begin
          fcnt[d] = 0;
          busy_m[d] = 1;
          start_cyc[d] = cyc + ((d == 0) ? LAT_LB : LAT_DLY) + 1;
          tx_n[d] = 0; got_n[d] = 0; wait_n[d] = 0;
          sm_e[d] = fb[d][0][0];
          sm_f[d] = fb[d][0][2:1];
          sm_g[d] = {fb[d][1], fb[d][2], fb[d][3]};
          for (int i = 0; i < 3; i++) sm_h[d][i] = fb[d][4 + i];
          for (int i = 0; i < 7; i++) begin
            exp_b = (i == 0) ? (fb[d][0] & 8'h07) : fb[d][i];
            if (d == 0) exp_q0.push_back(exp_b); else exp_q1.push_back(exp_b);
          end
        end
      end
    end
    if (!rst_n) armed = 1'b1;
  end

  // ---------------- drivers ----------------
  initial begin
    bit [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = pat[3 - (k % 4)];
        k++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input byte_t b);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (rdy[0] && rdy[1]) ok = 1;
    end
    check("in_ready_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [55:0] fr, input bit gap);
    for (int i = 0; i < 7; i++) begin
      if (gap && i == 3) begin
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      send_byte(fr[55 - 8*i -: 8]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (!bsy[0] && !bsy[1]) ok = 1;
    end
    check("idle_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_resp(input int d, input logic [55:0] v);
    check("resp_count", got_n[d], 7);
    for (int i = 0; i < 7; i++) check("resp_literal", got[d][i], v[55 - 8*i -: 8]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_out_valid", ov[0], 0);
    check("reset_sig_g", g_s[1], 24'h0);

    // Basic frame, free-flowing output
    send_frame(56'h05112233445566, 1'b0);
    wait_idle();
    check("A_sig_e", e_s[0], 1);
    check("A_sig_f", f_s[0], 2);
    check("A_sig_g", g_s[0], 24'h112233);
    check("A_sig_h0", h0[0], 8'h44);
    check("A_sig_h2", h0[2], 8'h66);
    check("A_sig_g_dly", g_s[1], 24'h112233);
    check_resp(0, 56'h05112233445566);
    check_resp(1, 56'h05112233445566);
    check("A_wait_lb", wait_n[0], LAT_LB);
    check("A_wait_dly", wait_n[1], LAT_DLY);

    // Backpressure and an in_valid gap mid-frame
    bp_mode = 1'b1;
    send_frame(56'h3CA55A0FF0817E, 1'b1);
    wait_idle();
    bp_mode = 1'b0;
    check_resp(0, 56'h04A55A0FF0817E);
    check_resp(1, 56'h04A55A0FF0817E);

    // Header junk bits ignored
    send_frame(56'hFA010203040506, 1'b0);
    wait_idle();
    check("C_sig_e", e_s[0], 0);
    check("C_sig_f", f_s[0], 1);
    check_resp(0, 56'h02010203040506);
    check_resp(1, 56'h02010203040506);

    // Reset with a partial frame, then a fresh frame
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    in_valid = 1'b0;
    pulse_reset();
    send_frame(56'hAA000102030405, 1'b0);
    wait_idle();
    check("D_sig_e", e_s[0], 0);
    check("D_sig_f", f_s[0], 1);
    check("D_sig_g", g_s[0], 24'h000102);
    check("D_sig_h0", h0[0], 8'h03);
    check("D_sig_h2", h1[2], 8'h05);
    check_resp(0, 56'h02000102030405);
    check_resp(1, 56'h02000102030405);

    // Reset in the middle of a response
    send_frame(56'h13DEADBEEF0102, 1'b0);
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (got_n[0] >= 3) ok = 1;
    end
    check("E_tx_timeout", ok, 1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("E_out_valid", ov[0], 0);
    check("E_in_ready", rdy[0], 1);
    check("E_busy", bsy[0], 0);
    @(posedge clk);
    #1;
    send_frame(56'h06C0FFEE123456, 1'b0);
    wait_idle();
    check("F_sig_f", f_s[0], 3);
    check_resp(0, 56'h06C0FFEE123456);
    check_resp(1, 56'h06C0FFEE123456);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/sub2_link.md
Name: sub2_link

Overview:
- Byte-stream bridge that drives the input bundle of sub2 (sig_e/f/g/h) and collects its output bundle (sig_i/j/k/l).
- Deserializes a 7-byte request frame onto sub2's inputs, waits a fixed response latency, captures sub2's outputs and serializes them as a 7-byte response frame.
- Sits between a valid/ready byte channel (host/test side) and one sub2 instance.

Parameters:
- RSP_LAT, 1, cycles between sub2 inputs becoming valid and output capture; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  request byte valid
- in_ready  output  1  request byte accepted when in_valid && in_ready
- in_data  input  8  request byte
- out_valid  output  1  response byte valid
- out_ready  input  1  response byte consumed when out_valid && out_ready
- out_data  output  8  response byte
- busy  output  1  high in WAIT or TX
- sig_e  output  1  to sub2 single signal
- sig_f  output  2  to sub2 vector
- sig_g  output  [0:2][7:0] packed  to sub2 packed array
- sig_h  output  [7:0] x [0:2] unpacked  to sub2 unpacked array
- sig_i  input  1  from sub2
- sig_j  input  2  from sub2
- sig_k  input  [0:2][7:0] packed  from sub2
- sig_l  input  [7:0] x [0:2] unpacked  from sub2

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=RX, byte count=0, wait count=0.
  - sig_e/f/g/h=0, out_valid=0, out_data=0, in_ready=0 during reset, busy=0.
  - Any partial frame is discarded.
- Request frame, 7 bytes in order:
  - B0 header: bit0 -> sig_e, bits[2:1] -> sig_f, bits[7:3] ignored.
  - B1..B3 -> sig_g[0], sig_g[1], sig_g[2].
  - B4..B6 -> sig_h[0], sig_h[1], sig_h[2].
- State RX:
  - in_ready=1.
  - Each accepted byte is stored in a staging register; byte count increments.
  - On acceptance of B6:
    - next cycle, all sig_e..sig_h update together from the staging register plus B6 (registered; never partially updated);
    - state -> WAIT, in_ready=0.
- State WAIT:
  - wait count runs 1..RSP_LAT.
  - The cycle wait count reaches RSP_LAT: capture sig_i/j/k/l into the response register, state -> TX.
- State TX:
  - out_valid=1; bytes are sent in this order:
    - R0 = {5'b0, sig_j, sig_i};
    - R1..R3 = sig_k[0..2];
    - R4..R6 = sig_l[0..2].
  - out_data is held stable while out_valid && !out_ready.
  - Advance only on handshake.
  - After R6 handshake: state -> RX, counts=0, out_valid=0.
- Latency: B6 accepted at cycle N -> sig_* valid from N+1 -> capture at N+RSP_LAT -> R0 valid at N+RSP_LAT+1.
- sig_e..sig_h hold their last frame's values until the next frame completes (they do not return to 0 between frames).
- in_ready is 0 in WAIT and TX; no request overlap, one frame in flight.
- in_valid low mid-frame: RX waits indefinitely, no timeout.
- Byte count wraps 6 -> 0 only via a frame-complete transition; it never exceeds 6.
- rst_n low in any state, including mid-TX with out_valid high, takes effect at that edge: out_valid drops next cycle and no partial response is resent.

Decomposition:
- Shared package sub2_pkg:
  - byte_t (logic [7:0]);
  - arr3_t (packed [0:2][7:0]);
  - FRAME_BYTES=7;
  - header bit positions (HDR_E=0, HDR_F_LSB=1);
  - state enum {RX, WAIT, TX}.
- No sub-module: single FSM plus staging/response registers.

Test Plan:
- Loopback stub (sig_i=sig_e, sig_j=sig_f, sig_k=sig_g, sig_l=sig_h), RSP_LAT=1.
  - Stimulus: send 05 11 22 33 44 55 66.
  - Response: sig_e=1, sig_f=2, sig_g={11,22,33}, sig_h={44,55,66} at N+1; response 05 11 22 33 44 55 66 with R0 at N+2.
- RSP_LAT=4, stub with 3-cycle registered delay.
  - Response: captured values equal frame inputs; in_ready=0 for exactly 4 WAIT cycles plus 7 TX bytes.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly.
  - Response: out_data stable while stalled; no byte duplicated or lost; 7 bytes total.
- Header junk: B0=FA.
  - Response: sig_e=0, sig_f=1, bits[7:3] ignored; R0=02 under loopback.
- Reset mid-RX after 3 bytes, then a full new frame AA 00 01 02 03 04 05.
  - Response: sig_* reflect only the new frame (sig_e=0, sig_f=1, sig_g={00,01,02}); no stale byte leaks.
- Reset during TX after R2.
  - Response: out_valid=0 the following cycle, state RX, in_ready=1; the next frame completes normally.
